// File: rtl/threat_move_issuer_pkg.sv
// Shared types and constants for the threat-finder consumer: board layout,
// piece encoding, list geometry and FSM state codes.
package threat_move_issuer_pkg;

  localparam int N        = 15;
  localparam int MAX_CAND = 10;
  localparam int COORD_W  = 5;
  localparam int CELLS    = N * N;

  localparam logic [1:0] PIECE_B = 2'd0;
  localparam logic [1:0] PIECE_W = 2'd1;
  localparam logic [1:0] PIECE_L = 2'd2;

  typedef logic [CELLS-1:0][1:0] board_t;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_SCAN = 2'd1;
  localparam state_t S_EMIT = 2'd2;
  localparam state_t S_DONE = 2'd3;

  function automatic logic [3:0] clamp_size(input logic [5:0] size);
    if (size > 6'(MAX_CAND)) return 4'(MAX_CAND);
    return size[3:0];
  endfunction

endpackage

// File: rtl/threat_move_issuer_if.sv
// Request, move-stream and status signals between the threat finder,
// the move issuer and the search/placement stage.
interface threat_move_issuer_if;
  import threat_move_issuer_pkg::*;

  logic                          i_start;
  board_t                        i_board;
  logic [MAX_CAND*COORD_W-1:0]   i_posX;
  logic [MAX_CAND*COORD_W-1:0]   i_posY;
  logic [5:0]                    i_size;
  logic [1:0]                    i_win;
  logic                          i_ready;

  logic                          o_valid;
  logic [3:0]                    o_x;
  logic [3:0]                    o_y;
  logic [3:0]                    o_idx;
  logic [3:0]                    o_count;
  logic [1:0]                    o_win;
  logic                          o_busy;
  logic                          o_finish;

  modport slave (
    input  i_start, i_board, i_posX, i_posY, i_size, i_win, i_ready,
    output o_valid, o_x, o_y, o_idx, o_count, o_win, o_busy, o_finish
  );

  modport master (
    output i_start, i_board, i_posX, i_posY, i_size, i_win, i_ready,
    input  o_valid, o_x, o_y, o_idx, o_count, o_win, o_busy, o_finish
  );

endinterface

// File: rtl/threat_move_issuer_cand_filter.sv
// Combinational validity check for list entry idx: on-board, empty cell,
// and not a repeat of any earlier entry in the latched list.
module threat_move_issuer_cand_filter
  import threat_move_issuer_pkg::*;
(
  input  logic [MAX_CAND*COORD_W-1:0] pos_x,
  input  logic [MAX_CAND*COORD_W-1:0] pos_y,
  input  board_t                      board,
  input  logic [3:0]                  idx,
  output logic [3:0]                  move_x,
  output logic [3:0]                  move_y,
  output logic                        cand_ok
);

  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic               in_range;
  logic               dup;
  logic [7:0]         cell_idx;

  always_comb begin
    cand_x = '0;
    cand_y = '0;
    dup    = 1'b0;
    for (int k = 0; k < MAX_CAND; k++) begin
      if (4'(k) == idx) begin
        cand_x = pos_x[k*COORD_W +: COORD_W];
        cand_y = pos_y[k*COORD_W +: COORD_W];
      end
    end
    // Earlier entries count as duplicates even if they were themselves rejected.
    for (int k = 0; k < MAX_CAND; k++) begin
      if (4'(k) < idx && pos_x[k*COORD_W +: COORD_W] == cand_x &&
          pos_y[k*COORD_W +: COORD_W] == cand_y)
        dup = 1'b1;
    end
    in_range = (cand_x < COORD_W'(N)) && (cand_y < COORD_W'(N));
    cell_idx = in_range ? (8'(cand_x) * 8'(N) + 8'(cand_y)) : 8'd0;
    cand_ok  = in_range && (board[cell_idx] == PIECE_L) && !dup;
    move_x   = cand_x[3:0];
    move_y   = cand_y[3:0];
  end

endmodule

// File: rtl/threat_move_issuer.sv
// Latches one threat-finder result, filters the candidate list and streams
// the surviving moves over valid/ready, then pulses o_finish.
module threat_move_issuer
  import threat_move_issuer_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  threat_move_issuer_if.slave  bus
);

  state_t                      state_q, state_d;
  logic [MAX_CAND*COORD_W-1:0] pos_x_q, pos_x_d;
  logic [MAX_CAND*COORD_W-1:0] pos_y_q, pos_y_d;
  board_t                      board_q, board_d;
  logic [3:0]                  size_q, size_d;
  logic [1:0]                  win_q, win_d;
  logic [3:0]                  idx_q, idx_d;
  logic [3:0]                  count_q, count_d;
  logic [3:0]                  x_q, x_d;
  logic [3:0]                  y_q, y_d;
  logic [3:0]                  out_idx_q, out_idx_d;

  logic [3:0] move_x;
  logic [3:0] move_y;
  logic       cand_ok;
  logic [3:0] size_eff;
  logic       last;

  threat_move_issuer_cand_filter u_filter (
    .pos_x   (pos_x_q),
    .pos_y   (pos_y_q),
    .board   (board_q),
    .idx     (idx_q),
    .move_x  (move_x),
    .move_y  (move_y),
    .cand_ok (cand_ok)
  );

  assign size_eff = clamp_size(bus.i_size);
  assign last     = (idx_q == size_q - 4'd1);

  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    board_d   = board_q;
    size_d    = size_q;
    win_d     = win_q;
    idx_d     = idx_q;
    count_d   = count_q;
    x_d       = x_q;
    y_d       = y_q;
    out_idx_d = out_idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          pos_x_d = bus.i_posX;
          pos_y_d = bus.i_posY;
          board_d = bus.i_board;
          win_d   = bus.i_win;
          size_d  = size_eff;
          idx_d   = 4'd0;
          count_d = 4'd0;
          state_d = (bus.i_win != 2'd0 || size_eff == 4'd0) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        if (cand_ok) begin
          x_d       = move_x;
          y_d       = move_y;
          out_idx_d = idx_q;
          state_d   = S_EMIT;
        end else if (last) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_EMIT: begin
        if (bus.i_ready) begin
          count_d = count_q + 4'd1;
          if (last) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_SCAN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Updates on the falling edge to line up with the threat-finder stage.
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      board_q   <= '0;
      size_q    <= '0;
      win_q     <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      out_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      board_q   <= board_d;
      size_q    <= size_d;
      win_q     <= win_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      x_q       <= x_d;
      y_q       <= y_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign bus.o_valid  = (state_q == S_EMIT);
  assign bus.o_finish = (state_q == S_DONE);
  assign bus.o_busy   = (state_q != S_IDLE);
  assign bus.o_x      = x_q;
  assign bus.o_y      = y_q;
  assign bus.o_idx    = out_idx_q;
  assign bus.o_count  = count_q;
  assign bus.o_win    = win_q;

endmodule

// File: tb/tb_threat_move_issuer.sv
// Scoreboard bench for threat_move_issuer: directed lists push expected moves
// and finish records; a monitor pops and compares on each handshake/finish.
module tb_threat_move_issuer;
  import threat_move_issuer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  threat_move_issuer_if bus();

  threat_move_issuer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] idx;
  } move_t;

  typedef struct {
    int count;
    int win;
  } fin_t;

  move_t  expMoves[$];
  fin_t   expFins[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     startCyc = 0;
  int     finishCnt = 0;
  int     tx[MAX_CAND];
  int     ty[MAX_CAND];
  board_t tbBoard;
  int     lat;
  int     fc;

  always @(negedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic clearEntries();
    for (int c = 0; c < CELLS; c++) tbBoard[c] = PIECE_L;
    for (int k = 0; k < MAX_CAND; k++) begin
      tx[k] = 31;
      ty[k] = 31;
    end
  endtask

  task automatic expectMove(input int x, input int y, input int idx);
    move_t m;
    m.x   = 4'(x);
    m.y   = 4'(y);
    m.idx = 4'(idx);
    expMoves.push_back(m);
  endtask

  task automatic expectFin(input int count, input int win);
    fin_t f;
    f.count = count;
    f.win   = win;
    expFins.push_back(f);
  endtask

  // Drives one start pulse just after the DUT's falling edge, then scrambles the inputs.
  task automatic applyStimulus(input int size, input int win, input logic ready);
    logic [MAX_CAND*COORD_W-1:0] px;
    logic [MAX_CAND*COORD_W-1:0] py;
    for (int k = 0; k < MAX_CAND; k++) begin
      px[k*COORD_W +: COORD_W] = COORD_W'(tx[k]);
      py[k*COORD_W +: COORD_W] = COORD_W'(ty[k]);
    end
    @(negedge clk); #1;
    bus.i_board = tbBoard;
    bus.i_posX  = px;
    bus.i_posY  = py;
    bus.i_size  = 6'(size);
    bus.i_win   = 2'(win);
    bus.i_ready = ready;
    bus.i_start = 1'b1;
    startCyc    = cyc;
    @(negedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_posX  = '1;
    bus.i_posY  = '0;
    bus.i_board = '0;
    bus.i_size  = 6'd1;
    bus.i_win   = 2'd0;
  endtask

  task automatic waitValid(output int latency);
    latency = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (bus.o_valid) begin
        latency = cyc - startCyc;
        return;
      end
    end
  endtask

  task automatic waitFinish(input int target);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (finishCnt >= target) return;
    end
    checkOutput("finish_timeout", finishCnt, target);
  endtask

  // Monitor: compares every accepted move and every finish pulse against the queues.
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.o_valid && bus.i_ready) begin
        if (expMoves.size() == 0) begin
          checkOutput("unexpected_move_x", int'(bus.o_x), -1);
        end else begin
          move_t m;
          m = expMoves.pop_front();
          checkOutput("move_x", int'(bus.o_x), int'(m.x));
          checkOutput("move_y", int'(bus.o_y), int'(m.y));
          checkOutput("move_idx", int'(bus.o_idx), int'(m.idx));
        end
      end
      if (bus.o_finish) begin
        finishCnt++;
        if (expFins.size() == 0) begin
          checkOutput("unexpected_finish_count", int'(bus.o_count), -1);
        end else begin
          fin_t f;
          f = expFins.pop_front();
          checkOutput("finish_count", int'(bus.o_count), f.count);
          checkOutput("finish_win", int'(bus.o_win), f.win);
          checkOutput("moves_left", expMoves.size(), 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    bus.i_start = 1'b0;
    bus.i_board = '0;
    bus.i_posX  = '0;
    bus.i_posY  = '0;
    bus.i_size  = '0;
    bus.i_win   = '0;
    bus.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    checkOutput("rst_valid", int'(bus.o_valid), 0);
    checkOutput("rst_finish", int'(bus.o_finish), 0);
    checkOutput("rst_busy", int'(bus.o_busy), 0);
    checkOutput("rst_count", int'(bus.o_count), 0);
    checkOutput("rst_win", int'(bus.o_win), 0);
    checkOutput("rst_x", int'(bus.o_x), 0);
    checkOutput("rst_y", int'(bus.o_y), 0);
    checkOutput("rst_idx", int'(bus.o_idx), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] test 1: duplicate filtered");
    clearEntries();
    tx[0] = 7; ty[0] = 7;
    tx[1] = 3; ty[1] = 4;
    tx[2] = 7; ty[2] = 7;
    expectMove(7, 7, 0);
    expectMove(3, 4, 1);
    expectFin(2, 0);
    fc = finishCnt;
    applyStimulus(3, 0, 1'b1);
    waitValid(lat);
    checkOutput("t1_latency", lat, 2);
    checkOutput("t1_busy", int'(bus.o_busy), 1);
    waitFinish(fc + 1);

    $display("[TB] test 2: occupied cell filtered");
    clearEntries();
    tbBoard[0] = PIECE_B;
    tx[0] = 0;  ty[0] = 0;
    tx[1] = 14; ty[1] = 14;
    expectMove(14, 14, 1);
    expectFin(1, 0);
    fc = finishCnt;
    applyStimulus(2, 0, 1'b1);
    waitValid(lat);
    checkOutput("t2_latency", lat, 3);
    waitFinish(fc + 1);

    $display("[TB] test 3: out-of-range filtered");
    clearEntries();
    tx[0] = 15; ty[0] = 2;
    tx[1] = 2;  ty[1] = 15;
    tx[2] = 5;  ty[2] = 5;
    expectMove(5, 5, 2);
    expectFin(1, 0);
    fc = finishCnt;
    applyStimulus(3, 0, 1'b1);
    waitValid(lat);
    checkOutput("t3_latency", lat, 4);
    waitFinish(fc + 1);

    $display("[TB] test 4: back-pressure");
    clearEntries();
    tx[0] = 9; ty[0] = 9;
    expectMove(9, 9, 0);
    expectFin(1, 0);
    fc = finishCnt;
    applyStimulus(1, 0, 1'b0);
    waitValid(lat);
    checkOutput("t4_latency", lat, 2);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      checkOutput("t4_hold_valid", int'(bus.o_valid), 1);
      checkOutput("t4_hold_x", int'(bus.o_x), 9);
      checkOutput("t4_hold_y", int'(bus.o_y), 9);
    end
    @(negedge clk); #1;
    bus.i_ready = 1'b1;
    waitFinish(fc + 1);

    $display("[TB] test 5: game already won");
    clearEntries();
    for (int k = 0; k < 4; k++) begin
      tx[k] = k + 1;
      ty[k] = k + 1;
    end
    expectFin(0, 1);
    fc = finishCnt;
    applyStimulus(4, 1, 1'b1);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (bus.o_finish) begin
        lat = cyc - startCyc;
        break;
      end
    end
    checkOutput("t5_finish_latency", lat, 1);
    waitFinish(fc + 1);
    repeat (2) @(posedge clk);
    checkOutput("t5_win_hold", int'(bus.o_win), 1);

    $display("[TB] test 6a: oversized list clamps to ten");
    clearEntries();
    for (int k = 0; k < MAX_CAND; k++) begin
      tx[k] = k;
      ty[k] = 14 - k;
      expectMove(k, 14 - k, k);
    end
    expectFin(10, 0);
    fc = finishCnt;
    applyStimulus(20, 0, 1'b1);
    waitFinish(fc + 1);

    $display("[TB] test 6b: reset during emit");
    clearEntries();
    tx[0] = 4; ty[0] = 4;
    expectMove(4, 4, 0);
    expectFin(1, 0);
    applyStimulus(1, 0, 1'b0);
    waitValid(lat);
    checkOutput("t6b_latency", lat, 2);
    @(negedge clk); #1;
    expMoves.delete();
    expFins.delete();
    fc = finishCnt;
    rst_n = 1'b0;
    #1;
    checkOutput("t6b_valid", int'(bus.o_valid), 0);
    checkOutput("t6b_busy", int'(bus.o_busy), 0);
    checkOutput("t6b_finish", int'(bus.o_finish), 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    repeat (5) @(posedge clk);
    checkOutput("t6b_no_finish", finishCnt, fc);
    checkOutput("t6b_count", int'(bus.o_count), 0);
    checkOutput("t6b_idle_busy", int'(bus.o_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
